// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: 8 opcodes, zero flag, opaque tag, valid/ready on both sides.
// The ready chain is combinational so empty stages are filled without waiting for the output.
module logic_unit_pipe #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LAST = PIPE_STAGES - 1;

    logic [PIPE_STAGES-1:0]            vld_q, vld_d;
    logic [PIPE_STAGES-1:0][WIDTH-1:0] res_q, res_d;
    logic [PIPE_STAGES-1:0]            zero_q, zero_d;
    logic [PIPE_STAGES-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [PIPE_STAGES-1:0]            adv;
    logic [PIPE_STAGES-1:0]            load;
    logic [WIDTH-1:0]                  res_p0;
    logic                              zero_p0;

    function automatic logic [WIDTH-1:0] logic_op(input logic [2:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a ^ b;
            3'b011:  r = ~(a | b);
            3'b100:  r = a & ~b;
            3'b101:  r = a | ~b;
            3'b110:  r = a;
            default: r = ~a;
        endcase
        return r;
    endfunction

    // ---- stage 0 input: combinational result and zero flag ----
    always_comb begin
        res_p0  = logic_op(in_op, in_a, in_b);
        zero_p0 = (res_p0 == '0);
    end

    // A stage loads when it is empty or its contents move on this cycle.
    always_comb begin
        adv       = '0;
        load      = '0;
        adv[LAST] = out_ready || !vld_q[LAST];
        for (int i = LAST - 1; i >= 0; i--) begin
            adv[i] = !vld_q[i+1] || adv[i+1];
        end
        for (int i = 0; i < PIPE_STAGES; i++) begin
            load[i] = !vld_q[i] || adv[i];
        end
    end

    assign in_ready = reset || load[0];

    always_comb begin
        vld_d  = vld_q;
        res_d  = res_q;
        zero_d = zero_q;
        tag_d  = tag_q;
        if (load[0]) begin
            vld_d[0] = in_valid;
            if (in_valid) begin
                res_d[0]  = res_p0;
                zero_d[0] = zero_p0;
                tag_d[0]  = in_tag;
            end
        end
        // ---- stages 1..LAST: pure data movement ----
        for (int i = 1; i < PIPE_STAGES; i++) begin
            if (load[i]) begin
                vld_d[i] = vld_q[i-1];
                if (vld_q[i-1]) begin
                    res_d[i]  = res_q[i-1];
                    zero_d[i] = zero_q[i-1];
                    tag_d[i]  = tag_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            res_q  <= '0;
            zero_q <= '0;
            tag_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            res_q  <= res_d;
            zero_q <= zero_d;
            tag_q  <= tag_d;
        end
    end

    // ---- output: straight from the last stage register ----
    assign out_valid  = vld_q[LAST];
    assign out_result = res_q[LAST];
    assign out_zero   = zero_q[LAST];
    assign out_tag    = tag_q[LAST];

endmodule
